// File: rtl/lut_seq_eval.sv
// Time-multiplexed evaluator for a mapped K-input LUT netlist: one LUT per clock,
// entries run in stored (topological) order against a shared net file.
module lut_seq_eval #(
  parameter int LUT_WIDTH = 4,
  parameter int NUM_IN    = 8,
  parameter int NUM_LUTS  = 16,
  localparam int NW       = $clog2(NUM_IN + NUM_LUTS)
) (
  input  logic                          CLK,
  input  logic                          SRST,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_LUTS)-1:0]   cfg_addr,
  input  logic [2**LUT_WIDTH-1:0]       cfg_init,
  input  logic [LUT_WIDTH*NW-1:0]       cfg_sel,
  input  logic                          start,
  input  logic [NUM_IN-1:0]             in_data,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_LUTS-1:0]           out_data
);

  localparam int AW    = $clog2(NUM_LUTS);
  localparam int NNETS = NUM_IN + NUM_LUTS;
  localparam int INITW = 2**LUT_WIDTH;

  typedef enum logic {IDLE, EVAL} state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW-1:0]           r_idx;
  logic [INITW-1:0]        r_init [NUM_LUTS];
  logic [LUT_WIDTH*NW-1:0] r_sel  [NUM_LUTS];
  logic [NNETS-1:0]        r_net, w_net_nxt;
  logic [NUM_LUTS-1:0]     r_out;
  logic                    r_done;
  logic [LUT_WIDTH-1:0]    w_addr;
  logic                    w_bit, w_last, w_cfg_wr, w_launch;

  always_ff @(posedge CLK) begin
    if (SRST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_cfg_wr    = 1'b0;
    w_last      = (r_idx == AW'(NUM_LUTS - 1));
    w_addr      = '0;
    w_bit       = 1'b0;
    w_net_nxt   = r_net;
    case (r_state)
      IDLE: begin
        w_cfg_wr = cfg_we && (int'(cfg_addr) < NUM_LUTS);
        if (start) begin
          w_launch    = 1'b1;
          w_state_nxt = EVAL;
        end
      end
      EVAL: begin
        // Selects beyond the net file match no k and so read 0.
        for (int unsigned j = 0; j < LUT_WIDTH; j++)
          for (int unsigned k = 0; k < NNETS; k++)
            if (r_sel[r_idx][j*NW +: NW] == NW'(k)) w_addr[j] = r_net[k];
        w_bit = r_init[r_idx][w_addr];
        for (int unsigned i = 0; i < NUM_LUTS; i++)
          if (r_idx == AW'(i)) w_net_nxt[NUM_IN + i] = w_bit;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_idx  <= '0;
      r_done <= 1'b0;
      r_out  <= '0;
      r_net  <= '0;
      for (int unsigned i = 0; i < NUM_LUTS; i++) begin
        r_init[i] <= '0;
        r_sel[i]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (w_cfg_wr) begin
        r_init[cfg_addr] <= cfg_init;
        r_sel[cfg_addr]  <= cfg_sel;
      end
      if (w_launch) begin
        r_net <= {{NUM_LUTS{1'b0}}, in_data};
        r_idx <= '0;
      end else if (r_state == EVAL) begin
        r_net <= w_net_nxt;
        if (w_last) begin
          r_idx  <= '0;
          r_done <= 1'b1;
          r_out  <= w_net_nxt[NNETS-1:NUM_IN];
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state == EVAL);
  assign done     = r_done;
  assign out_data = r_out;

endmodule

// File: tb/tb_lut_seq_eval.sv
// Randomized bench for lut_seq_eval, checked against a loop-based netlist model.
module tb_lut_seq_eval;

  localparam int K  = 4;
  localparam int NI = 8;
  localparam int NL = 16;
  localparam int NW = 5;

  logic             CLK = 1'b0;
  logic             SRST = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_addr = '0;
  logic [15:0]      cfg_init = '0;
  logic [K*NW-1:0]  cfg_sel = '0;
  logic             start = 1'b0;
  logic [NI-1:0]    in_data = '0;
  logic             busy, done;
  logic [NL-1:0]    out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]     m_init [NL];
  logic [K*NW-1:0] m_sel  [NL];
  logic [15:0]     last_exp = '0;

  lut_seq_eval #(.LUT_WIDTH(K), .NUM_IN(NI), .NUM_LUTS(NL)) dut (
    .CLK(CLK), .SRST(SRST), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_init(cfg_init), .cfg_sel(cfg_sel), .start(start), .in_data(in_data),
    .busy(busy), .done(done), .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*NW-1:0] mk_sel(input int s3, input int s2, input int s1, input int s0);
    return {NW'(s3), NW'(s2), NW'(s1), NW'(s0)};
  endfunction

  function automatic logic [15:0] model_eval(input logic [NI-1:0] din);
    int net [NI+NL];
    int s, a;
    logic [15:0] res;
    for (int n = 0; n < NI + NL; n++) net[n] = (n < NI) ? int'(din[n]) : 0;
    for (int i = 0; i < NL; i++) begin
      a = 0;
      for (int j = 0; j < K; j++) begin
        s = int'((m_sel[i] >> (j * NW)) & 20'h1F);
        if (s < NI + NL) a += net[s] << j;
      end
      net[NI + i] = int'((m_init[i] >> a) & 16'h1);
    end
    for (int i = 0; i < NL; i++) res[i] = net[NI + i][0];
    return res;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      m_init[i] = '0;
      m_sel[i]  = '0;
    end
    last_exp = '0;
  endtask

  task automatic do_reset(input int n);
    SRST = 1'b1;
    repeat (n) @(negedge CLK);
    SRST = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] init, input logic [K*NW-1:0] sel);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_init = init; cfg_sel = sel;
    @(negedge CLK);
    cfg_we = 1'b0;
    m_init[addr] = init;
    m_sel[addr]  = sel;
  endtask

  // Events at step k are sampled by the DUT at edge e+k+1.
  task automatic run_check(input string tag, input logic [NI-1:0] din,
                           input int restart_at, input int cfgw_at, input int rst_at);
    logic [15:0] exp;
    int k;
    bit got, held;
    exp = model_eval(din);
    in_data = din; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    in_data = NI'($urandom);
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_out_held"}, out_data, last_exp);
    k = 0; got = 0; held = 1;
    while (k < 40 && !got) begin
      if (k == restart_at) begin start = 1'b1; in_data = NI'($urandom); end
      if (k == cfgw_at) begin
        cfg_we = 1'b1; cfg_addr = '0;
        cfg_init = 16'($urandom); cfg_sel = 20'($urandom);
      end
      if (k == rst_at) SRST = 1'b1;
      @(negedge CLK);
      k++;
      start = 1'b0; cfg_we = 1'b0;
      if (SRST) begin
        SRST = 1'b0;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_out"}, out_data, 0);
        model_clear();
        return;
      end
      if (done) got = 1;
      else if (!busy) held = 0;
    end
    chk({tag, "_latency"}, k, 16);
    chk({tag, "_busy_held"}, held, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_out"}, out_data, exp);
    last_exp = exp;
  endtask

  initial begin
    model_clear();
    do_reset(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out_data, 0);

    run_check("empty", 8'hFF, -1, -1, -1);
    chk("empty_zero", out_data, 16'h0000);

    cfg_write(0, 16'h8888, mk_sel(0, 0, 1, 0));
    run_check("and11", 8'h03, -1, -1, -1);
    chk("and11_bit", out_data[0], 1);
    run_check("and10", 8'h01, -1, -1, -1);
    chk("and10_bit", out_data[0], 0);

    cfg_write(0, 16'h6666, mk_sel(0, 0, 1, 0));
    cfg_write(1, 16'h5555, mk_sel(8, 8, 8, 8));
    cfg_write(2, 16'hCACA, mk_sel(8, 8, 3, 2));
    run_check("chain07", 8'h07, -1, -1, -1);
    run_check("chain0D", 8'h0D, -1, -1, -1);

    cfg_write(0, 16'hAAAA, mk_sel(9, 9, 9, 9));
    run_check("fwdref", 8'($urandom), -1, -1, -1);
    chk("fwdref_bit", out_data[0], 0);
    cfg_write(0, 16'hAAAA, mk_sel(31, 31, 31, 31));
    run_check("oorange", 8'($urandom), -1, -1, -1);
    chk("oorange_bit", out_data[0], 0);

    cfg_write(0, 16'hFFFF, mk_sel(0, 0, 0, 0));
    run_check("busyprot", 8'h5A, 2, 4, -1);
    run_check("busyprot_after", 8'hA5, -1, -1, -1);
    chk("busyprot_entry0", out_data[0], 1);

    run_check("midrst", 8'h3C, -1, -1, 6);
    run_check("postrst", 8'hFF, -1, -1, -1);
    chk("postrst_zero", out_data, 16'h0000);

    for (int r = 0; r < 12; r++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, NL - 1)), 16'($urandom), 20'($urandom));
      run_check("rand", 8'($urandom), -1, -1, -1);
      if (r % 3 == 0) run_check("rand_b2b", 8'($urandom), -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
